rf_read_mux: RTL and testbench
==============================

Name: rf_read_mux

Overview:
- Read-side counterpart of the write-back register-file demux in the 4-thread fine-grained multithreaded pipeline.
- Broadcasts ID-stage read addresses to the four per-thread register files and selects the read data of the issuing thread.
- Applies WB-to-ID forwarding and registers operands into the ID/EX pipeline register.
- Keeps a per-thread scoreboard of in-flight writes and raises a hazard stall request on RAW/WAW conflicts.

Parameters:
DATA_W, 64, register data width
ADDR_W, 3, register address width (8 registers per thread)
NUM_THREADS, 4, fixed; thread ID width is 2

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
thread_ID  in  2  thread of instruction in ID
valid_ID  in  1  ID holds a real instruction
raddr0_ID  in  3  source 0 address
raddr1_ID  in  3  source 1 address
rs0_used_ID  in  1  source 0 read by instruction
rs1_used_ID  in  1  source 1 read by instruction
waddr_ID  in  3  destination address
WRE_ID  in  1  instruction writes destination
rf_rdata0_bus  in  256  {RF3,RF2,RF1,RF0} port-0 read data, combinational RF read
rf_rdata1_bus  in  256  same for port 1
thread_WB  in  2  write-back thread
waddr_WB  in  3  write-back address
wdata_WB  in  64  write-back data
WRE_WB  in  1  write-back enable
stall  in  1  downstream stall, freeze ID/EX
flush  in  1  kill ID instruction this cycle
raddr0_RF  out  3  = raddr0_ID, combinational, to all RFs
raddr1_RF  out  3  = raddr1_ID, combinational
hazard_stall  out  1  combinational stall request to fetch/ID
rdata0_EX  out  64  registered operand 0
rdata1_EX  out  64  registered operand 1
waddr_EX  out  3  registered destination
WRE_EX  out  1  registered write enable, qualified by valid_EX
thread_EX  out  2  registered thread
valid_EX  out  1  registered valid
fwd0_EX, fwd1_EX  out  1 each  registered: operand came from WB forward

Behaviour:
- Reset (reset_n low, async): all registered outputs 0, entire scoreboard (4x8 pending bits) cleared.
- Select: rfN = slice thread_ID of the bus (RF0 = bits [63:0]).
- Forward: fwdK = WRE_WB & (thread_WB==thread_ID) & (waddr_WB==raddrK_ID); operand = fwdK ? wdata_WB : rfN data.
- Hazard:
  - pendK = pending[thread_ID][raddrK_ID]; pendD = pending[thread_ID][waddr_ID].
  - clrD = WB clears the destination entry this cycle.
  - hazard_stall = valid_ID & ~flush & ((rs0_used & pend0 & ~fwd0) | (rs1_used & pend1 & ~fwd1) | (WRE_ID & pendD & ~clrD)).
  - WAW stall guarantees at most one outstanding write per (thread, reg), so one pending bit suffices.
- issue = valid_ID & ~flush & ~stall & ~hazard_stall.
- ID/EX register, 1-cycle latency:
  - stall high: hold all EX registers, including valid.
  - Otherwise, capture operands, waddr, thread, fwd flags; valid_EX <= issue; WRE_EX <= issue & WRE_ID.
  - On a bubble (flush or hazard), the data fields may update but valid_EX=0 and WRE_EX=0.
- Scoreboard:
  - Set pending[thread_ID][waddr_ID] on issue & WRE_ID.
  - Clear pending[thread_WB][waddr_WB] on WRE_WB.
  - Set and clear on the same entry in the same cycle: set wins, because the new writer is younger.
  - WRE_WB with no pending bit is legal and has no error.
- flush kills only the ID instruction: no scoreboard set, no EX valid. It does not alter pending bits of already-issued instructions.
- Reset mid-operation clears everything immediately; any in-flight WB after reset release clears an already-zero bit, which is harmless.

Decomposition:
- Shared package rf_pkg: DATA_W, ADDR_W, NUM_THREADS, thread ID width, bus slice macro/function.
- Sub-module rf_scoreboard: 4x8 pending array, set/clear ports, two read lookups plus the destination lookup.
- Muxing, forwarding and the ID/EX register stay in the top level.

Test Plan:
- Reset, then thread_ID=2, raddr0=1, RF2 port0=0xAA, valid_ID=1 -> next cycle rdata0_EX=0xAA, thread_EX=2, valid_EX=1, fwd0_EX=0.
- WB thread 1, r3 = 0x55, WRE_WB=1 while ID thread 1 reads r3 (RF1 shows stale 0x11) -> rdata0_EX=0x55, fwd0_EX=1; the same read from thread 0 gets its RF0 value, fwd0_EX=0.
- Issue thread 0 write r4, then thread 0 reads r4 next cycle -> hazard_stall=1, valid_EX=0. Then WB thread 0 r4 = 0x77 -> hazard_stall=0, rdata0_EX=0x77.
- Thread 3 writes r2 pending, then a second thread-3 write to r2 -> hazard_stall=1 (WAW). Thread 1 write to r2 in the same window -> no stall.
- Same-cycle issue of a thread 0 write to r5 and WB clearing thread 0 r5 -> pending stays 1, and the next read of r5 stalls.
- stall=1 for 3 cycles with changing inputs -> EX outputs frozen. flush=1 -> valid_EX=0, no pending bit set. reset_n pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, ID/EX payload and helpers for the register-file read path
// of the 4-thread pipeline.
package rf_pkg;

    localparam int unsigned DATA_W      = 64;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned TID_W       = 2;
    localparam int unsigned NUM_REGS    = 1 << ADDR_W;
    localparam int unsigned BUS_W       = DATA_W * NUM_THREADS;
    localparam int unsigned SB_W        = NUM_THREADS * NUM_REGS;
    localparam int unsigned SB_IDX_W    = TID_W + ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] rdata0;
        logic [DATA_W-1:0] rdata1;
        logic [ADDR_W-1:0] waddr;
        logic              wre;
        logic [TID_W-1:0]  thread;
        logic              valid;
        logic              fwd0;
        logic              fwd1;
    } id_ex_t;

    // Per-thread word of a concatenated {RF3,RF2,RF1,RF0} read bus.
    function automatic logic [DATA_W-1:0] rf_slice(input logic [BUS_W-1:0] bus,
                                                   input logic [TID_W-1:0] tid);
        logic [DATA_W-1:0] word;
        word = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (tid == TID_W'(t)) word = bus[t*DATA_W +: DATA_W];
        end
        return word;
    endfunction

    // Flat scoreboard index for (thread, register).
    function automatic logic [SB_IDX_W-1:0] sb_idx(input logic [TID_W-1:0]  tid,
                                                   input logic [ADDR_W-1:0] addr);
        return {tid, addr};
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-thread pending-write scoreboard: one bit per (thread, register),
// set on issue of a writer, cleared on write-back; set wins on collision.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [TID_W-1:0]  set_thread,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [TID_W-1:0]  clr_thread,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [TID_W-1:0]  lkp_thread,
    input  logic [ADDR_W-1:0] lkp_addr0,
    input  logic [ADDR_W-1:0] lkp_addr1,
    input  logic [ADDR_W-1:0] lkp_waddr,
    output logic              pend0_c,
    output logic              pend1_c,
    output logic              pendd_c
);

    logic [SB_W-1:0] pending_q;
    logic [SB_W-1:0] pending_d;

    // Clear applied first so a younger writer's set survives.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[sb_idx(clr_thread, clr_addr)] = 1'b0;
        if (set_en) pending_d[sb_idx(set_thread, set_addr)] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign pend0_c = pending_q[sb_idx(lkp_thread, lkp_addr0)];
    assign pend1_c = pending_q[sb_idx(lkp_thread, lkp_addr1)];
    assign pendd_c = pending_q[sb_idx(lkp_thread, lkp_waddr)];

endmodule

// File: rtl/rf_read_mux.sv
// ID-stage register read: per-thread RF select, WB->ID forwarding,
// scoreboard hazard detection and the ID/EX operand register.
module rf_read_mux
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TID_W-1:0]  thread_ID,
    input  logic              valid_ID,
    input  logic [ADDR_W-1:0] raddr0_ID,
    input  logic [ADDR_W-1:0] raddr1_ID,
    input  logic              rs0_used_ID,
    input  logic              rs1_used_ID,
    input  logic [ADDR_W-1:0] waddr_ID,
    input  logic              WRE_ID,
    input  logic [BUS_W-1:0]  rf_rdata0_bus,
    input  logic [BUS_W-1:0]  rf_rdata1_bus,
    input  logic [TID_W-1:0]  thread_WB,
    input  logic [ADDR_W-1:0] waddr_WB,
    input  logic [DATA_W-1:0] wdata_WB,
    input  logic              WRE_WB,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] raddr0_RF,
    output logic [ADDR_W-1:0] raddr1_RF,
    output logic              hazard_stall,
    output logic [DATA_W-1:0] rdata0_EX,
    output logic [DATA_W-1:0] rdata1_EX,
    output logic [ADDR_W-1:0] waddr_EX,
    output logic              WRE_EX,
    output logic [TID_W-1:0]  thread_EX,
    output logic              valid_EX,
    output logic              fwd0_EX,
    output logic              fwd1_EX
);

    logic   wb_same_thread_c;
    logic   fwd0_c;
    logic   fwd1_c;
    logic   clrd_c;
    logic   pend0_c;
    logic   pend1_c;
    logic   pendd_c;
    logic   live_c;
    logic   issue_c;
    id_ex_t ex_q;
    id_ex_t ex_d;

    assign raddr0_RF = raddr0_ID;
    assign raddr1_RF = raddr1_ID;

    assign wb_same_thread_c = WRE_WB & (thread_WB == thread_ID);
    assign fwd0_c           = wb_same_thread_c & (waddr_WB == raddr0_ID);
    assign fwd1_c           = wb_same_thread_c & (waddr_WB == raddr1_ID);
    assign clrd_c           = wb_same_thread_c & (waddr_WB == waddr_ID);

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_en     (issue_c & WRE_ID),
        .set_thread (thread_ID),
        .set_addr   (waddr_ID),
        .clr_en     (WRE_WB),
        .clr_thread (thread_WB),
        .clr_addr   (waddr_WB),
        .lkp_thread (thread_ID),
        .lkp_addr0  (raddr0_ID),
        .lkp_addr1  (raddr1_ID),
        .lkp_waddr  (waddr_ID),
        .pend0_c    (pend0_c),
        .pend1_c    (pend1_c),
        .pendd_c    (pendd_c)
    );

    // RAW on either used source unless forwarded; WAW unless WB retires it now.
    assign live_c       = valid_ID & ~flush;
    assign hazard_stall = live_c & ((rs0_used_ID & pend0_c & ~fwd0_c) |
                                    (rs1_used_ID & pend1_c & ~fwd1_c) |
                                    (WRE_ID      & pendd_c & ~clrd_c));
    assign issue_c      = live_c & ~stall & ~hazard_stall;

    always_comb begin
        ex_d = ex_q;
        if (!stall) begin
            ex_d.rdata0 = fwd0_c ? wdata_WB : rf_slice(rf_rdata0_bus, thread_ID);
            ex_d.rdata1 = fwd1_c ? wdata_WB : rf_slice(rf_rdata1_bus, thread_ID);
            ex_d.waddr  = waddr_ID;
            ex_d.wre    = issue_c & WRE_ID;
            ex_d.thread = thread_ID;
            ex_d.valid  = issue_c;
            ex_d.fwd0   = fwd0_c;
            ex_d.fwd1   = fwd1_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    assign rdata0_EX = ex_q.rdata0;
    assign rdata1_EX = ex_q.rdata1;
    assign waddr_EX  = ex_q.waddr;
    assign WRE_EX    = ex_q.wre;
    assign thread_EX = ex_q.thread;
    assign valid_EX  = ex_q.valid;
    assign fwd0_EX   = ex_q.fwd0;
    assign fwd1_EX   = ex_q.fwd1;

endmodule

// File: tb/tb_rf_read_mux.sv
// Bench for rf_read_mux: directed scenarios plus random traffic against a
// behavioural model (pending table, in-flight write list, expected EX stage).
module tb_rf_read_mux;

    logic         clk;
    logic         reset_n;
    logic [1:0]   thread_ID;
    logic         valid_ID;
    logic [2:0]   raddr0_ID, raddr1_ID, waddr_ID;
    logic         rs0_used_ID, rs1_used_ID, WRE_ID;
    logic [255:0] rf_rdata0_bus, rf_rdata1_bus;
    logic [1:0]   thread_WB;
    logic [2:0]   waddr_WB;
    logic [63:0]  wdata_WB;
    logic         WRE_WB, stall, flush;
    logic [2:0]   raddr0_RF, raddr1_RF;
    logic         hazard_stall;
    logic [63:0]  rdata0_EX, rdata1_EX;
    logic [2:0]   waddr_EX;
    logic         WRE_EX;
    logic [1:0]   thread_EX;
    logic         valid_EX, fwd0_EX, fwd1_EX;

    rf_read_mux dut (
        .clk(clk), .reset_n(reset_n), .thread_ID(thread_ID), .valid_ID(valid_ID),
        .raddr0_ID(raddr0_ID), .raddr1_ID(raddr1_ID), .rs0_used_ID(rs0_used_ID),
        .rs1_used_ID(rs1_used_ID), .waddr_ID(waddr_ID), .WRE_ID(WRE_ID),
        .rf_rdata0_bus(rf_rdata0_bus), .rf_rdata1_bus(rf_rdata1_bus),
        .thread_WB(thread_WB), .waddr_WB(waddr_WB), .wdata_WB(wdata_WB), .WRE_WB(WRE_WB),
        .stall(stall), .flush(flush), .raddr0_RF(raddr0_RF), .raddr1_RF(raddr1_RF),
        .hazard_stall(hazard_stall), .rdata0_EX(rdata0_EX), .rdata1_EX(rdata1_EX),
        .waddr_EX(waddr_EX), .WRE_EX(WRE_EX), .thread_EX(thread_EX), .valid_EX(valid_EX),
        .fwd0_EX(fwd0_EX), .fwd1_EX(fwd1_EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model state: expected EX stage, pending table, list of in-flight writers.
    bit          m_pend [4][8];
    logic [63:0] m_rd0, m_rd1;
    logic [2:0]  m_wa;
    logic [1:0]  m_th;
    logic        m_wre, m_v, m_f0, m_f1;
    int          inflight[$];

    function automatic logic [63:0] word_of(input logic [255:0] bus, input int t);
        logic [255:0] b;
        b = bus;
        return b[t*64 +: 64];
    endfunction

    task automatic model_reset();
        foreach (m_pend[t, r]) m_pend[t][r] = 1'b0;
        m_rd0 = '0; m_rd1 = '0; m_wa = '0; m_th = '0;
        m_wre = 1'b0; m_v = 1'b0; m_f0 = 1'b0; m_f1 = 1'b0;
        inflight.delete();
    endtask

    task automatic idle();
        thread_ID = '0; valid_ID = 1'b0; raddr0_ID = '0; raddr1_ID = '0;
        rs0_used_ID = 1'b0; rs1_used_ID = 1'b0; waddr_ID = '0; WRE_ID = 1'b0;
        rf_rdata0_bus = '0; rf_rdata1_bus = '0;
        thread_WB = '0; waddr_WB = '0; wdata_WB = '0; WRE_WB = 1'b0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_bus(input int t, input logic [63:0] v0, input logic [63:0] v1);
        rf_rdata0_bus[t*64 +: 64] = v0;
        rf_rdata1_bus[t*64 +: 64] = v1;
    endtask

    task automatic check_ex();
        check("valid_EX",  64'(valid_EX),  64'(m_v));
        check("WRE_EX",    64'(WRE_EX),    64'(m_wre));
        check("thread_EX", 64'(thread_EX), 64'(m_th));
        check("waddr_EX",  64'(waddr_EX),  64'(m_wa));
        check("rdata0_EX", rdata0_EX,      m_rd0);
        check("rdata1_EX", rdata1_EX,      m_rd1);
        check("fwd0_EX",   64'(fwd0_EX),   64'(m_f0));
        check("fwd1_EX",   64'(fwd1_EX),   64'(m_f1));
    endtask

    // One cycle: inputs already driven after a negedge.
    task automatic step();
        bit haz, iss, f0, f1, rawh, wawh;
        int t;
        t    = int'(thread_ID);
        f0   = WRE_WB && thread_WB == thread_ID && waddr_WB == raddr0_ID;
        f1   = WRE_WB && thread_WB == thread_ID && waddr_WB == raddr1_ID;
        rawh = (rs0_used_ID && m_pend[t][raddr0_ID] && !f0) ||
               (rs1_used_ID && m_pend[t][raddr1_ID] && !f1);
        wawh = WRE_ID && m_pend[t][waddr_ID] &&
               !(WRE_WB && thread_WB == thread_ID && waddr_WB == waddr_ID);
        haz  = valid_ID && !flush && (rawh || wawh);
        iss  = valid_ID && !flush && !stall && !haz;
        #1;
        check("hazard_stall", 64'(hazard_stall), 64'(haz));
        check("raddr0_RF", 64'(raddr0_RF), 64'(raddr0_ID));
        check("raddr1_RF", 64'(raddr1_RF), 64'(raddr1_ID));
        @(posedge clk);
        if (!stall) begin
            m_rd0 = f0 ? wdata_WB : word_of(rf_rdata0_bus, t);
            m_rd1 = f1 ? wdata_WB : word_of(rf_rdata1_bus, t);
            m_wa  = waddr_ID;
            m_th  = thread_ID;
            m_v   = iss;
            m_wre = iss && WRE_ID;
            m_f0  = f0;
            m_f1  = f1;
        end
        if (WRE_WB) begin
            m_pend[thread_WB][waddr_WB] = 1'b0;
            for (int i = inflight.size() - 1; i >= 0; i--)
                if (inflight[i] == int'(thread_WB) * 8 + int'(waddr_WB)) inflight.delete(i);
        end
        if (iss && WRE_ID) begin
            m_pend[t][waddr_ID] = 1'b1;
            inflight.push_back(t * 8 + int'(waddr_ID));
        end
        @(negedge clk);
        check_ex();
    endtask

    task automatic async_reset();
        idle();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid_EX", 64'(valid_EX), 64'd0);
        check("rst_WRE_EX", 64'(WRE_EX), 64'd0);
        check("rst_rdata0_EX", rdata0_EX, 64'd0);
        check("rst_rdata1_EX", rdata1_EX, 64'd0);
        check("rst_thread_EX", 64'(thread_EX), 64'd0);
        check("rst_waddr_EX", 64'(waddr_EX), 64'd0);
        check("rst_fwd", 64'({fwd0_EX, fwd1_EX}), 64'd0);
        check("rst_hazard", 64'(hazard_stall), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_inputs();
        int v;
        valid_ID    = ($urandom_range(0, 99) < 85);
        thread_ID   = 2'($urandom_range(0, 3));
        raddr0_ID   = 3'($urandom_range(0, 7));
        raddr1_ID   = 3'($urandom_range(0, 7));
        rs0_used_ID = ($urandom_range(0, 9) < 7);
        rs1_used_ID = ($urandom_range(0, 9) < 7);
        waddr_ID    = 3'($urandom_range(0, 7));
        WRE_ID      = ($urandom_range(0, 9) < 6);
        for (int i = 0; i < 8; i++) begin
            rf_rdata0_bus[i*32 +: 32] = $urandom;
            rf_rdata1_bus[i*32 +: 32] = $urandom;
        end
        wdata_WB = {$urandom, $urandom};
        WRE_WB   = 1'b0;
        if (inflight.size() > 0 && $urandom_range(0, 9) < 4) begin
            v = inflight[$urandom_range(0, inflight.size() - 1)];
            thread_WB = 2'(v / 8);
            waddr_WB  = 3'(v % 8);
            WRE_WB    = 1'b1;
        end else if ($urandom_range(0, 9) == 0) begin
            thread_WB = 2'($urandom_range(0, 3));
            waddr_WB  = 3'($urandom_range(0, 7));
            WRE_WB    = 1'b1;
        end
        stall = ($urandom_range(0, 99) < 15);
        flush = ($urandom_range(0, 99) < 8);
    endtask

    logic [63:0] frozen_rd0;

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        #12;
        check("reset_valid_EX", 64'(valid_EX), 64'd0);
        check("reset_rdata0_EX", rdata0_EX, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Thread select.
        idle(); thread_ID = 2'd2; raddr0_ID = 3'd1; rs0_used_ID = 1'b1; valid_ID = 1'b1;
        set_bus(2, 64'hAA, 64'h0); set_bus(0, 64'h99, 64'h0);
        step();
        check("sel_rd0", rdata0_EX, 64'hAA);
        check("sel_thread", 64'(thread_EX), 64'd2);
        check("sel_valid", 64'(valid_EX), 64'd1);
        check("sel_fwd0", 64'(fwd0_EX), 64'd0);

        // WB forwarding, same thread vs other thread.
        idle(); thread_ID = 2'd1; raddr0_ID = 3'd3; rs0_used_ID = 1'b1; valid_ID = 1'b1;
        set_bus(1, 64'h11, 64'h0); set_bus(0, 64'h22, 64'h0);
        thread_WB = 2'd1; waddr_WB = 3'd3; wdata_WB = 64'h55; WRE_WB = 1'b1;
        step();
        check("fwd_rd0", rdata0_EX, 64'h55);
        check("fwd_flag", 64'(fwd0_EX), 64'd1);
        thread_ID = 2'd0;
        step();
        check("nofwd_rd0", rdata0_EX, 64'h22);
        check("nofwd_flag", 64'(fwd0_EX), 64'd0);

        // RAW stall, released by write-back.
        idle(); valid_ID = 1'b1; WRE_ID = 1'b1; waddr_ID = 3'd4;
        step();
        idle(); valid_ID = 1'b1; rs0_used_ID = 1'b1; raddr0_ID = 3'd4;
        #1 check("raw_stall", 64'(hazard_stall), 64'd1);
        step();
        check("raw_bubble", 64'(valid_EX), 64'd0);
        thread_WB = 2'd0; waddr_WB = 3'd4; wdata_WB = 64'h77; WRE_WB = 1'b1;
        #1 check("raw_release", 64'(hazard_stall), 64'd0);
        step();
        check("raw_fwd_rd0", rdata0_EX, 64'h77);

        // WAW stall is per thread.
        idle(); valid_ID = 1'b1; thread_ID = 2'd3; WRE_ID = 1'b1; waddr_ID = 3'd2;
        step();
        #1 check("waw_stall", 64'(hazard_stall), 64'd1);
        step();
        thread_ID = 2'd1;
        #1 check("waw_other_thread", 64'(hazard_stall), 64'd0);
        step();

        // Same-cycle set and clear: set wins.
        idle(); valid_ID = 1'b1; WRE_ID = 1'b1; waddr_ID = 3'd5;
        step();
        thread_WB = 2'd0; waddr_WB = 3'd5; WRE_WB = 1'b1;
        step();
        check("setclr_issue", 64'(valid_EX), 64'd1);
        idle(); valid_ID = 1'b1; rs1_used_ID = 1'b1; raddr1_ID = 3'd5;
        #1 check("setclr_pending", 64'(hazard_stall), 64'd1);
        step();

        // Downstream stall freezes EX.
        idle(); valid_ID = 1'b1; thread_ID = 2'd2; raddr0_ID = 3'd7; set_bus(2, 64'hC0DE, 64'h1);
        step();
        frozen_rd0 = m_rd0;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            stall = 1'b1;
            step();
            check("stall_hold_rd0", rdata0_EX, frozen_rd0);
            check("stall_hold_valid", 64'(valid_EX), 64'd1);
        end

        // Flush kills instruction without marking its destination.
        idle(); valid_ID = 1'b1; thread_ID = 2'd2; WRE_ID = 1'b1; waddr_ID = 3'd6; flush = 1'b1;
        step();
        check("flush_valid", 64'(valid_EX), 64'd0);
        check("flush_wre", 64'(WRE_EX), 64'd0);
        idle(); valid_ID = 1'b1; thread_ID = 2'd2; rs0_used_ID = 1'b1; raddr0_ID = 3'd6;
        #1 check("flush_no_pending", 64'(hazard_stall), 64'd0);
        step();

        // Random traffic with an asynchronous reset mid-stream.
        for (int n = 0; n < 500; n++) begin
            if (n == 250) async_reset();
            random_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
